// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU operand collector.
//   src_sel_e  : where a source operand comes from (immediate, GRF, bypass)
//   fsm_e      : operand collector control states
//   NO_DEP_TAG : wide all-ones; compare its low TAG_W bits for "no dependency"
//   RS_IDX_W   : GRF register index width
package alu_issue_pkg;

  localparam int unsigned RS_IDX_W = 5;

  // Wider than any sensible tag; users slice [TAG_W-1:0].
  localparam logic [31:0] NO_DEP_TAG = '1;

  typedef enum logic [1:0] {SRC_IMM, SRC_GRF, SRC_BYP} src_sel_e;

  typedef enum logic [1:0] {IDLE, LOAD, REQ, ISSUE} fsm_e;

  function automatic src_sel_e selectSrc(input logic useImm, input logic noDep);
    if (useImm) begin
      return SRC_IMM;
    end else if (noDep) begin
      return SRC_GRF;
    end
    return SRC_BYP;
  endfunction

endpackage

// File: rtl/alu_oc_channel.sv
// One operand channel of the collector: picks the source at head load, issues a
// GRF or bypass request, captures the matching response into the operand register.
// Ports:
//   clk, rstn, flush        : clock, async active-low reset, sync flush
//   load                    : latch head fields this cycle
//   useImm/rsIdx/depTag/imm : head instruction fields for this channel
//   grfReq*/grfRsp*         : GRF request (valid/ready) and response
//   bypReq*/bypRsp*         : bypass request (valid/ready) and response
//   doneNow                 : operand ready, including a capture happening this cycle
//   drain                   : waiting to swallow a response orphaned by flush
//   operand                 : collected operand value
module alu_oc_channel
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                load,
  input  logic                useImm,
  input  logic [RS_IDX_W-1:0] rsIdx,
  input  logic [TAG_W-1:0]    depTag,
  input  logic [DATA_W-1:0]   imm,
  output logic                grfReqValid,
  input  logic                grfReqReady,
  output logic [RS_IDX_W-1:0] grfReqIdx,
  input  logic                grfRspValid,
  input  logic [DATA_W-1:0]   grfRspData,
  output logic                bypReqValid,
  input  logic                bypReqReady,
  output logic [TAG_W-1:0]    bypReqTag,
  input  logic                bypRspValid,
  input  logic [DATA_W-1:0]   bypRspData,
  output logic                doneNow,
  output logic                drain,
  output logic [DATA_W-1:0]   operand
);

  src_sel_e            srcQ;
  logic [RS_IDX_W-1:0] idxQ;
  logic [TAG_W-1:0]    tagQ;
  logic                reqPendQ, rspPendQ, doneQ, drainQ;
  logic [DATA_W-1:0]   operandQ;

  src_sel_e          loadSrc;
  logic              reqReady, rspValid, accept, outstanding, capture;
  logic [DATA_W-1:0] rspData;

  assign loadSrc = selectSrc(useImm, depTag == NO_DEP_TAG[TAG_W-1:0]);

  // Only the selected source's handshake and response are seen by this channel.
  always_comb begin
    reqReady = 1'b0;
    rspValid = 1'b0;
    rspData  = grfRspData;
    case (srcQ)
      SRC_GRF: begin
        reqReady = grfReqReady;
        rspValid = grfRspValid;
        rspData  = grfRspData;
      end
      SRC_BYP: begin
        reqReady = bypReqReady;
        rspValid = bypRspValid;
        rspData  = bypRspData;
      end
      default: ;
    endcase
  end

  assign accept      = reqPendQ & reqReady;
  // A response may arrive in the same cycle as its request is accepted.
  assign outstanding = rspPendQ | accept;
  assign capture     = outstanding & rspValid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      srcQ     <= SRC_IMM;
      idxQ     <= '0;
      tagQ     <= '0;
      reqPendQ <= 1'b0;
      rspPendQ <= 1'b0;
      doneQ    <= 1'b0;
      drainQ   <= 1'b0;
      operandQ <= '0;
    end else if (flush) begin
      reqPendQ <= 1'b0;
      rspPendQ <= 1'b0;
      doneQ    <= 1'b0;
      // An accepted request will still answer; remember to swallow it.
      drainQ   <= (outstanding | drainQ) & ~rspValid;
    end else if (load) begin
      srcQ     <= loadSrc;
      idxQ     <= rsIdx;
      tagQ     <= depTag;
      reqPendQ <= (loadSrc != SRC_IMM);
      rspPendQ <= 1'b0;
      doneQ    <= (loadSrc == SRC_IMM);
      if (loadSrc == SRC_IMM) begin
        operandQ <= imm;
      end
    end else begin
      if (accept) begin
        reqPendQ <= 1'b0;
      end
      rspPendQ <= outstanding & ~rspValid;
      if (capture) begin
        operandQ <= rspData;
        doneQ    <= 1'b1;
      end
      if (drainQ && rspValid) begin
        drainQ <= 1'b0;
      end
    end
  end

  assign grfReqValid = reqPendQ & (srcQ == SRC_GRF);
  assign bypReqValid = reqPendQ & (srcQ == SRC_BYP);
  assign grfReqIdx   = idxQ;
  assign bypReqTag   = tagQ;
  assign doneNow     = doneQ | capture;
  assign drain       = drainQ;
  assign operand     = operandQ;

endmodule

// File: rtl/alu_operand_collector.sv
// ALU operand collector: queues decoded instructions, gathers NSRC operands for the
// head from immediate, GRF or bypass in parallel, then issues the bundle to EXE.
// Ports:
//   clk, rstn, flush                 : clock, async active-low reset, sync flush
//   in_valid/in_ready, in_*          : instruction push from issue
//   grf_req_*/grf_rsp_*              : per-channel GRF read request/response
//   byp_req_*/byp_rsp_*              : per-channel bypass request/response
//   exe_valid/exe_ready, exe_*       : issued instruction and operand vector
module alu_operand_collector
  import alu_issue_pkg::*;
#(
  parameter int unsigned INSTR_W = 115,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [NSRC*RS_IDX_W-1:0]   in_rs_idx,
  input  logic [NSRC*TAG_W-1:0]      in_dep_tag,
  input  logic [NSRC-1:0]            in_use_imm,
  input  logic [DATA_W-1:0]          in_imm,
  output logic [NSRC-1:0]            grf_req_valid,
  input  logic [NSRC-1:0]            grf_req_ready,
  output logic [NSRC*RS_IDX_W-1:0]   grf_req_idx,
  input  logic [NSRC-1:0]            grf_rsp_valid,
  input  logic [NSRC*DATA_W-1:0]     grf_rsp_data,
  output logic [NSRC-1:0]            byp_req_valid,
  input  logic [NSRC-1:0]            byp_req_ready,
  output logic [NSRC*TAG_W-1:0]      byp_req_tag,
  input  logic [NSRC-1:0]            byp_rsp_valid,
  input  logic [NSRC*DATA_W-1:0]     byp_rsp_data,
  output logic                       exe_valid,
  input  logic                       exe_ready,
  output logic [INSTR_W-1:0]         exe_instr,
  output logic [NSRC*DATA_W-1:0]     exe_operands
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [INSTR_W-1:0]       qInstr  [DEPTH];
  logic [NSRC*RS_IDX_W-1:0] qRsIdx  [DEPTH];
  logic [NSRC*TAG_W-1:0]    qDepTag [DEPTH];
  logic [NSRC-1:0]          qUseImm [DEPTH];
  logic [DATA_W-1:0]        qImm    [DEPTH];

  logic [PTR_W-1:0]   wrPtrQ, rdPtrQ;
  logic [CNT_W-1:0]   countQ, countD;
  fsm_e               stateQ, stateD;
  logic [INSTR_W-1:0] instrQ;
  logic               push, pop, load, full, empty;
  logic [NSRC-1:0]    chDone, chDrain;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (countQ == CNT_W'(DEPTH));
  assign empty    = (countQ == '0);
  assign in_ready = ~full;
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = (stateQ == ISSUE) & exe_ready & ~flush;
  assign load     = (stateQ == LOAD) & ~flush;

  always_comb begin
    countD = countQ + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      countD = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else if (flush) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (push) begin
        wrPtrQ <= ptrInc(wrPtrQ);
      end
      if (pop) begin
        rdPtrQ <= ptrInc(rdPtrQ);
      end
      countQ <= countD;
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      qInstr[wrPtrQ]  <= in_instr;
      qRsIdx[wrPtrQ]  <= in_rs_idx;
      qDepTag[wrPtrQ] <= in_dep_tag;
      qUseImm[wrPtrQ] <= in_use_imm;
      qImm[wrPtrQ]    <= in_imm;
    end
  end

  always_comb begin
    stateD = stateQ;
    if (flush) begin
      stateD = IDLE;
    end else begin
      case (stateQ)
        IDLE:    if (!empty && (chDrain == '0)) stateD = LOAD;
        // All-immediate instructions have nothing to fetch.
        LOAD:    stateD = (&qUseImm[rdPtrQ]) ? ISSUE : REQ;
        REQ:     if (&chDone) stateD = ISSUE;
        ISSUE:   if (exe_ready) stateD = (countD != '0) ? LOAD : IDLE;
        default: stateD = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stateQ <= IDLE;
      instrQ <= '0;
    end else begin
      stateQ <= stateD;
      if (load) begin
        instrQ <= qInstr[rdPtrQ];
      end
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : gChan
    alu_oc_channel #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W)
    ) uChan (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .load       (load),
      .useImm     (qUseImm[rdPtrQ][i]),
      .rsIdx      (qRsIdx[rdPtrQ][i*RS_IDX_W +: RS_IDX_W]),
      .depTag     (qDepTag[rdPtrQ][i*TAG_W +: TAG_W]),
      .imm        (qImm[rdPtrQ]),
      .grfReqValid(grf_req_valid[i]),
      .grfReqReady(grf_req_ready[i]),
      .grfReqIdx  (grf_req_idx[i*RS_IDX_W +: RS_IDX_W]),
      .grfRspValid(grf_rsp_valid[i]),
      .grfRspData (grf_rsp_data[i*DATA_W +: DATA_W]),
      .bypReqValid(byp_req_valid[i]),
      .bypReqReady(byp_req_ready[i]),
      .bypReqTag  (byp_req_tag[i*TAG_W +: TAG_W]),
      .bypRspValid(byp_rsp_valid[i]),
      .bypRspData (byp_rsp_data[i*DATA_W +: DATA_W]),
      .doneNow    (chDone[i]),
      .drain      (chDrain[i]),
      .operand    (exe_operands[i*DATA_W +: DATA_W])
    );
  end

  assign exe_valid = (stateQ == ISSUE);
  assign exe_instr = instrQ;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed self-checking bench for alu_operand_collector (default parameters).
module tb_alu_operand_collector;

  localparam int unsigned INSTR_W = 115;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NSRC    = 2;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned DEPTH   = 2;

  logic                   clk = 1'b0;
  logic                   rstn, flush, in_valid, in_ready;
  logic [INSTR_W-1:0]     in_instr;
  logic [NSRC*5-1:0]      in_rs_idx;
  logic [NSRC*TAG_W-1:0]  in_dep_tag;
  logic [NSRC-1:0]        in_use_imm;
  logic [DATA_W-1:0]      in_imm;
  logic [NSRC-1:0]        grf_req_valid, grf_req_ready, grf_rsp_valid;
  logic [NSRC*5-1:0]      grf_req_idx;
  logic [NSRC*DATA_W-1:0] grf_rsp_data, byp_rsp_data, exe_operands;
  logic [NSRC-1:0]        byp_req_valid, byp_req_ready, byp_rsp_valid;
  logic [NSRC*TAG_W-1:0]  byp_req_tag;
  logic                   exe_valid, exe_ready;
  logic [INSTR_W-1:0]     exe_instr;

  int checks = 0;
  int failures = 0;

  alu_operand_collector #(
    .INSTR_W(INSTR_W), .DATA_W(DATA_W), .NSRC(NSRC), .TAG_W(TAG_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_idx(in_rs_idx), .in_dep_tag(in_dep_tag), .in_use_imm(in_use_imm),
    .in_imm(in_imm),
    .grf_req_valid(grf_req_valid), .grf_req_ready(grf_req_ready),
    .grf_req_idx(grf_req_idx), .grf_rsp_valid(grf_rsp_valid),
    .grf_rsp_data(grf_rsp_data),
    .byp_req_valid(byp_req_valid), .byp_req_ready(byp_req_ready),
    .byp_req_tag(byp_req_tag), .byp_rsp_valid(byp_rsp_valid),
    .byp_rsp_data(byp_rsp_data),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_instr(exe_instr),
    .exe_operands(exe_operands)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush = 0; in_valid = 0; in_instr = '0; in_rs_idx = '0; in_dep_tag = '1;
    in_use_imm = '0; in_imm = '0; grf_req_ready = '0; grf_rsp_valid = '0;
    grf_rsp_data = '0; byp_req_ready = '0; byp_rsp_valid = '0; byp_rsp_data = '0;
    exe_ready = 0;
  endtask

  task automatic drive_instr(input logic [INSTR_W-1:0] instr, input logic [1:0] use_imm,
                             input logic [9:0] idx, input logic [7:0] tags,
                             input logic [31:0] imm);
    in_valid = 1; in_instr = instr; in_use_imm = use_imm; in_rs_idx = idx;
    in_dep_tag = tags; in_imm = imm;
  endtask

  task automatic test_reset;
    idle_inputs();
    rstn = 0;
    in_valid = 1;
    #3;
    checks++; if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (exe_valid !== 1'b0) begin
      failures++; $display("FAIL rst_exe_valid: got %b want 0", exe_valid); end
    checks++; if ({grf_req_valid, byp_req_valid} !== 4'b0) begin
      failures++; $display("FAIL rst_req_valid: got %b want 0", {grf_req_valid, byp_req_valid});
    end
    tick(); tick();
    checks++; if (exe_instr !== '0 || exe_operands !== '0) begin
      failures++; $display("FAIL rst_payload: got %h/%h want 0", exe_instr, exe_operands); end
    checks++; if (grf_req_idx !== '0 || byp_req_tag !== '0) begin
      failures++; $display("FAIL rst_idx_tag: got %h/%h want 0", grf_req_idx, byp_req_tag); end
    in_valid = 0;
    rstn = 1;
    tick();
  endtask

  task automatic test_imm_latency;
    drive_instr(1, 2'b11, '0, 8'hFF, 32'h55);  // T
    tick(); in_valid = 0;                      // T+1
    checks++; if (exe_valid !== 1'b0) begin
      failures++; $display("FAIL imm_t1: exe_valid got %b want 0", exe_valid); end
    tick();                                    // T+2
    checks++; if (exe_valid !== 1'b0) begin
      failures++; $display("FAIL imm_t2: exe_valid got %b want 0", exe_valid); end
    tick();                                    // T+3
    checks++; if (exe_valid !== 1'b1) begin
      failures++; $display("FAIL imm_t3: exe_valid got %b want 1", exe_valid); end
    checks++; if (exe_instr !== INSTR_W'(1)) begin
      failures++; $display("FAIL imm_instr: got %h want 1", exe_instr); end
    checks++; if (exe_operands !== {32'h55, 32'h55}) begin
      failures++; $display("FAIL imm_ops: got %h want 5555", exe_operands); end
    exe_ready = 1; tick(); exe_ready = 0;
    checks++; if (exe_valid !== 1'b0) begin
      failures++; $display("FAIL imm_pop: exe_valid got %b want 0", exe_valid); end
  endtask

  task automatic test_grf_byp;
    grf_req_ready = 2'b11; byp_req_ready = 2'b11;
    drive_instr(2, 2'b00, {5'd0, 5'd3}, {4'h2, 4'hF}, 32'h0);
    tick(); in_valid = 0; tick(); tick();      // R
    checks++; if (grf_req_valid !== 2'b01 || grf_req_idx[4:0] !== 5'd3) begin
      failures++; $display("FAIL gb_grf_req: got %b/%0d want 01/3", grf_req_valid,
                           grf_req_idx[4:0]); end
    checks++; if (byp_req_valid !== 2'b10 || byp_req_tag[7:4] !== 4'h2) begin
      failures++; $display("FAIL gb_byp_req: got %b/%h want 10/2", byp_req_valid,
                           byp_req_tag[7:4]); end
    tick();                                    // R+1
    checks++; if ({grf_req_valid, byp_req_valid} !== 4'b0) begin
      failures++; $display("FAIL gb_req_drop: got %b want 0", {grf_req_valid, byp_req_valid});
    end
    tick();                                    // R+2
    grf_rsp_valid = 2'b01; grf_rsp_data = {32'h0, 32'hAAAA0001};
    tick(); grf_rsp_valid = 0;                 // R+3
    checks++; if (exe_valid !== 1'b0) begin
      failures++; $display("FAIL gb_early: exe_valid got %b want 0", exe_valid); end
    tick(); tick();                            // R+5
    byp_rsp_valid = 2'b10; byp_rsp_data = {32'hBBBB0002, 32'h0};
    checks++; if (exe_valid !== 1'b0) begin
      failures++; $display("FAIL gb_before_byp: exe_valid got %b want 0", exe_valid); end
    tick(); byp_rsp_valid = 0;                 // R+6
    checks++; if (exe_valid !== 1'b1) begin
      failures++; $display("FAIL gb_issue: exe_valid got %b want 1", exe_valid); end
    checks++; if (exe_operands !== {32'hBBBB0002, 32'hAAAA0001} || exe_instr !== INSTR_W'(2))
    begin
      failures++; $display("FAIL gb_payload: got %h/%h want bbbb0002aaaa0001/2",
                           exe_operands, exe_instr); end
    exe_ready = 1; tick(); exe_ready = 0;
    grf_req_ready = 0; byp_req_ready = 0;
  endtask

  task automatic test_queue_wrap;
    int pushIdx = 2;
    int popIdx = 0;
    bit pushing;
    logic [INSTR_W-1:0] expInstr;
    drive_instr(INSTR_W'(32'h10), 2'b11, '0, 8'hFF, 32'h10); tick();
    drive_instr(INSTR_W'(32'h11), 2'b11, '0, 8'hFF, 32'h11); tick();
    drive_instr(INSTR_W'(32'h12), 2'b11, '0, 8'hFF, 32'h12);
    checks++; if (in_ready !== 1'b0) begin
      failures++; $display("FAIL q_full: in_ready got %b want 0", in_ready); end
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin
      failures++; $display("FAIL q_full_hold: in_ready got %b want 0", in_ready); end
    exe_ready = 1;
    for (int cyc = 0; cyc < 60 && popIdx < 5; cyc++) begin
      if (pushIdx < 5) drive_instr(INSTR_W'(32'h10 + pushIdx), 2'b11, '0, 8'hFF,
                                   32'h10 + pushIdx);
      else in_valid = 0;
      pushing = in_valid && in_ready;
      if (exe_valid) begin
        expInstr = INSTR_W'(32'h10 + popIdx);
        checks++; if (exe_instr !== expInstr) begin
          failures++; $display("FAIL q_order%0d: got %h want %h", popIdx, exe_instr, expInstr);
        end
        checks++; if (exe_operands[31:0] !== 32'h10 + popIdx) begin
          failures++; $display("FAIL q_op%0d: got %h want %h", popIdx, exe_operands[31:0],
                               32'h10 + popIdx); end
        popIdx++;
      end
      tick();
      if (pushing) pushIdx++;
    end
    in_valid = 0; exe_ready = 0;
    checks++; if (popIdx != 5) begin
      failures++; $display("FAIL q_count: issued %0d want 5", popIdx); end
  endtask

  task automatic test_stall_same_cycle_rsp;
    drive_instr(3, 2'b00, {5'd9, 5'd7}, 8'hFF, 32'h0);
    tick(); in_valid = 0; tick(); tick();      // R
    for (int i = 0; i < 4; i++) begin
      checks++; if (grf_req_valid !== 2'b11 || grf_req_idx !== {5'd9, 5'd7} ||
                    exe_valid !== 1'b0) begin
        failures++; $display("FAIL stall%0d: got v=%b idx=%h exe=%b want 11/%h/0", i,
                             grf_req_valid, grf_req_idx, exe_valid, {5'd9, 5'd7}); end
      tick();
    end
    grf_req_ready = 2'b11; grf_rsp_valid = 2'b11;
    grf_rsp_data = {32'hC0DE0009, 32'hC0DE0007};
    tick(); grf_req_ready = 0; grf_rsp_valid = 0;
    checks++; if (grf_req_valid !== 2'b00 || exe_valid !== 1'b1) begin
      failures++; $display("FAIL stall_issue: got v=%b exe=%b want 00/1", grf_req_valid,
                           exe_valid); end
    checks++; if (exe_operands !== {32'hC0DE0009, 32'hC0DE0007}) begin
      failures++; $display("FAIL stall_ops: got %h want c0de0009c0de0007", exe_operands); end
    exe_ready = 1; tick(); exe_ready = 0;
  endtask

  task automatic test_flush_drain;
    byp_req_ready = 2'b11;
    drive_instr(INSTR_W'(32'h30), 2'b01, '0, {4'h5, 4'hF}, 32'h7);
    tick(); in_valid = 0; tick(); tick();      // R
    checks++; if (byp_req_valid !== 2'b10) begin
      failures++; $display("FAIL fl_req: got %b want 10", byp_req_valid); end
    tick();                                    // R+1: response outstanding
    flush = 1;
    drive_instr(INSTR_W'(32'h99), 2'b11, '0, 8'hFF, 32'h99);
    tick(); flush = 0;                         // R+2
    checks++; if (exe_valid !== 1'b0 || byp_req_valid !== 2'b00) begin
      failures++; $display("FAIL fl_deassert: got exe=%b v=%b want 0/00", exe_valid,
                           byp_req_valid); end
    drive_instr(INSTR_W'(32'h31), 2'b01, '0, {4'h6, 4'hF}, 32'h8);
    for (int i = 3; i <= 5; i++) begin
      tick(); in_valid = 0;                    // R+3 .. R+5
      if (i == 4) begin
        byp_rsp_valid = 2'b10; byp_rsp_data = {32'hDEAD, 32'h0};
      end else begin
        byp_rsp_valid = 0;
      end
      checks++; if (byp_req_valid !== 2'b00) begin
        failures++; $display("FAIL fl_blocked_r%0d: byp_req_valid got %b want 00", i,
                             byp_req_valid); end
    end
    tick(); tick();                            // R+7
    checks++; if (byp_req_valid !== 2'b10 || byp_req_tag[7:4] !== 4'h6) begin
      failures++; $display("FAIL fl_new_req: got %b/%h want 10/6", byp_req_valid,
                           byp_req_tag[7:4]); end
    byp_rsp_valid = 2'b10; byp_rsp_data = {32'h1234, 32'h0};
    tick(); byp_rsp_valid = 0;                 // R+8
    checks++; if (exe_valid !== 1'b1 || exe_instr !== INSTR_W'(32'h31)) begin
      failures++; $display("FAIL fl_issue: got exe=%b instr=%h want 1/31", exe_valid,
                           exe_instr); end
    checks++; if (exe_operands !== {32'h1234, 32'h8}) begin
      failures++; $display("FAIL fl_ops: got %h want 0000123400000008", exe_operands); end
    exe_ready = 1; tick(); exe_ready = 0;
    tick(); tick(); tick();
    checks++; if (exe_valid !== 1'b0) begin
      failures++; $display("FAIL fl_no_ghost: exe_valid got %b want 0", exe_valid); end
    byp_req_ready = 0;
  endtask

  task automatic test_stray_rsp;
    grf_req_ready = 2'b01; byp_req_ready = 2'b11;
    drive_instr(INSTR_W'(32'h40), 2'b00, {5'd2, 5'd1}, 8'hFF, 32'h0);
    tick(); in_valid = 0; tick(); tick();      // R
    checks++; if (grf_req_valid !== 2'b11) begin
      failures++; $display("FAIL st_req: got %b want 11", grf_req_valid); end
    tick();                                    // R+1
    checks++; if (grf_req_valid !== 2'b10) begin
      failures++; $display("FAIL st_req1: got %b want 10", grf_req_valid); end
    grf_rsp_valid = 2'b10; grf_rsp_data = {32'hBAD1, 32'h0};
    byp_rsp_valid = 2'b11; byp_rsp_data = {32'hBAD2, 32'hBAD3};
    tick();                                    // R+2
    byp_rsp_valid = 0; grf_rsp_valid = 2'b01; grf_rsp_data = {32'h0, 32'h1111};
    checks++; if (exe_valid !== 1'b0) begin
      failures++; $display("FAIL st_early2: exe_valid got %b want 0", exe_valid); end
    tick();                                    // R+3
    grf_rsp_valid = 0; grf_req_ready = 2'b10;
    checks++; if (exe_valid !== 1'b0) begin
      failures++; $display("FAIL st_early3: exe_valid got %b want 0", exe_valid); end
    tick();                                    // R+4
    grf_req_ready = 0; grf_rsp_valid = 2'b10; grf_rsp_data = {32'h2222, 32'h0};
    tick(); grf_rsp_valid = 0;                 // R+5
    checks++; if (exe_valid !== 1'b1) begin
      failures++; $display("FAIL st_issue: exe_valid got %b want 1", exe_valid); end
    checks++; if (exe_operands !== {32'h2222, 32'h1111}) begin
      failures++; $display("FAIL st_ops: got %h want 0000222200001111", exe_operands); end
    exe_ready = 1; tick(); exe_ready = 0;
  endtask

  initial begin
    test_reset();
    test_imm_latency();
    test_grf_byp();
    test_queue_wrap();
    test_stall_same_cycle_rsp();
    test_flush_drain();
    test_stray_rsp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Parametrised, clocked successor to the ALU issue stage.
- Buffers decoded ALU instructions in a DEPTH-entry queue.
- For each of NSRC source operands of the head instruction, fetches the value from the GRF (no dependency), the bypass buffer (dependency tag valid) or the immediate field. Requests go out in parallel; responses are collected in any order.
- Issues instruction plus operand vector to EXE over valid/ready. Supports flush with safe draining of in-flight responses.

Parameters:
- INSTR_W, 115, opaque instruction payload width forwarded to EXE.
- DATA_W, 32, operand width.
- NSRC, 2, operand channels (L/R generalised).
- TAG_W, 4, dependency tag width; all-ones = no dependency.
- DEPTH, 2, instruction queue depth (power of 2, >=1).

Ports:
- clk in 1: single clock, rising edge.
- rstn in 1: asynchronous, active-low reset.
- flush in 1: synchronous; discards queue and current instruction.
- in_valid in 1 / in_ready out 1: instruction handshake from issue.
- in_instr in INSTR_W: payload.
- in_rs_idx in NSRC*5: GRF index per source.
- in_dep_tag in NSRC*TAG_W: bypass tag per source.
- in_use_imm in NSRC: source i takes immediate.
- in_imm in DATA_W: immediate value.
- grf_req_valid out NSRC / grf_req_ready in NSRC: GRF read request per channel.
- grf_req_idx out NSRC*5: GRF read index.
- grf_rsp_valid in NSRC / grf_rsp_data in NSRC*DATA_W: GRF read response (no backpressure).
- byp_req_valid out NSRC / byp_req_ready in NSRC: bypass request per channel.
- byp_req_tag out NSRC*TAG_W: bypass tag.
- byp_rsp_valid in NSRC / byp_rsp_data in NSRC*DATA_W: bypass response.
- exe_valid out 1 / exe_ready in 1: issue handshake to EXE.
- exe_instr out INSTR_W / exe_operands out NSRC*DATA_W: issued bundle; operand i at [i*DATA_W +: DATA_W].

Behaviour:
- Reset (rstn low, asynchronous): queue empty; FSM IDLE; all pending/done/drain bits 0. Outputs: in_ready=1, exe_valid=0, all req_valid=0, exe_instr=0, exe_operands=0, req idx/tag=0.
- Queue:
  - Push on in_valid&&in_ready; in_ready = !full.
  - Pop when FSM leaves ISSUE. Simultaneous push+pop when full is not allowed (in_ready=0).
  - Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Per-channel source select at head load:
  - use_imm -> IMM: done immediately, operand=in_imm.
  - Else tag==all-ones -> GRF.
  - Else -> BYP.
- FSM:
  - IDLE: if queue non-empty and !flush -> LOAD.
  - LOAD (1 cycle): latch head fields; set done for IMM channels; set req_pend for GRF/BYP channels -> REQ.
  - REQ: req_valid held per channel until its ready; on accept, clear req_pend and set rsp_pend. The matching rsp_valid captures data into the operand register and sets done; a response in the same cycle as the accept is legal. When all done -> ISSUE.
  - ISSUE: exe_valid=1, payload stable until exe_ready. On handshake, pop and -> IDLE, or -> LOAD the next cycle if the queue is still non-empty.
- Latency:
  - All-IMM instruction pushed into an empty queue at cycle T -> exe_valid at T+3 (IDLE T+1, LOAD T+2).
  - Otherwise exe_valid is asserted the cycle after the last response is captured.
- Responses on a channel with no rsp_pend and no drain are ignored. Only the requested source's response is captured; the other source's rsp on that channel is ignored.
- Flush (highest priority, any state):
  - Queue emptied; FSM -> IDLE; req_valid and exe_valid deassert the next cycle.
  - Any channel with rsp_pend=1 sets drain; its next response on that source is consumed and dropped, then drain clears.
  - LOAD of a new instruction is blocked until all drain bits clear.
  - in_valid during flush is ignored.
- Reset mid-operation discards everything; no drain persists.

Decomposition:
- Shared package alu_issue_pkg: src_sel_e {SRC_IMM, SRC_GRF, SRC_BYP}, fsm_e {IDLE, LOAD, REQ, ISSUE}, constant NO_DEP_TAG = all-ones of TAG_W, RS_IDX_W=5.
- Sub-module alu_oc_channel (instantiated NSRC times): per-channel req_pend/rsp_pend/done/drain bits, source select, operand register.
- Queue inline in the top.

Test Plan:
- Reset with in_valid=1 -> in_ready=1, exe_valid=0, all req_valid=0. Release, push instr 0x1 with use_imm=2'b11, imm=0x55 -> exe_valid at T+3, operands {0x55,0x55}.
- Src0 GRF idx 3, src1 BYP tag 2; grf_rsp 0xAAAA0001 at +2, byp_rsp 0xBBBB0002 at +5 -> exe_valid the cycle after the byp rsp, operands[0]=0xAAAA0001, operands[1]=0xBBBB0002.
- Fill DEPTH=2 queue with exe_ready=0 -> in_ready=0 after 2 pushes. Release exe_ready -> in-order issue, pointer wrap verified over 5 instructions.
- Both channels GRF; grf_req_ready=0 for 4 cycles -> grf_req_valid held with stable idx, no issue; response in the same cycle as accept captured.
- Flush while src1 byp rsp pending; push new instr with src1 BYP -> stale byp_rsp 0xDEAD dropped, new rsp 0x1234 issued. LOAD delayed until drain clears.
- Stray grf_rsp_valid on a non-pending channel, and byp_rsp on a GRF channel -> ignored, operand unchanged.
